c3_heap_pq_unit: RTL and testbench
==================================

// Module: c3_heap_pq_unit
// PURPOSE
//  Responder side of the C3 custom-SIMD instruction interface: a hardware min-heap priority queue.
//  Takes one request per accepted in_v (opcode on vrd1), runs a multi-cycle sift FSM, returns
//  one out_v response with the result, echoed tag and status. Sits behind the core's custom-instr slot.
// PARAMETERS
//  DW     32  key/data width (in_data, out_data)
//  DEPTH  16  heap capacity in entries (power of 2, >=2)
//  VLEN   32  vector operand width (in_vdata*/out_vdata*)
// PORTS
//  clk        in   1      single clock, all logic posedge
//  reset      in   1      synchronous, active-low (0 = reset, sampled on posedge clk)
//  in_v       in   1      request valid; sampled only when busy=0
//  rd         in   5      dest tag, echoed on out_rd
//  vrd1       in   3      opcode: 0 NOP, 1 PUSH, 2 POP, 3 PEEK, 4 CLEAR, 5-7 reserved
//  vrd2       in   3      vector tag, echoed on out_vrd1
//  in_data    in   DW     PUSH key
//  in_vdata1  in   VLEN   unused, ignored
//  in_vdata2  in   VLEN   captured at accept, returned on out_vdata2
//  busy       out  1      1 while a request is in flight; in_v ignored (dropped, no response)
//  out_v      out  1      one-cycle response strobe
//  out_rd     out  5      captured rd
//  out_vrd1   out  3      captured vrd2
//  out_vrd2   out  3      status {full,empty,err} after the op
//  out_data   out  DW     POP/PEEK result; 0 otherwise
//  out_vdata1 out  VLEN   entry count after op, zero-extended
//  out_vdata2 out  VLEN   captured in_vdata2
// BEHAVIOUR
//  Reset (reset=0 at posedge): state IDLE, count=0, busy=0, out_v=0, all out_* =0; heap RAM not cleared.
//  Reset mid-operation aborts the op: no response, heap contents become undefined, count=0.
//  Accept: in_v=1 & busy=0 at posedge -> capture rd/vrd2/vdata2/opcode/in_data; busy=1 next cycle.
//  FSM: IDLE -> SIFT_UP (PUSH ok) | SIFT_DN (POP ok, count>1 after removal) | RESP (all others).
//   SIFT_UP: idx starts at old count; each cycle compare heap[idx] vs heap[(idx-1)>>1];
//     swap if child<parent (strict, unsigned), else or idx==0 -> RESP.
//   SIFT_DN: root<=heap[count-1], count--; each cycle pick smaller child (left on tie,
//     right only if in range); swap if child<node strictly, else/no child -> RESP.
//   RESP: out_v=1 for exactly one cycle with all outputs valid, busy=0 same cycle -> IDLE.
//   New request may be accepted in the RESP cycle's following posedge (busy low in RESP).
//  Latency accept->out_v: NOP/PEEK/CLEAR/errors 2 cycles; PUSH/POP <= 2+log2(DEPTH) cycles.
//  PUSH full: no change, err=1. POP empty: out_data=0, err=1. PEEK empty: out_data=0, err=1.
//  PEEK: out_data=heap[0], no change. CLEAR: count=0. Reserved opcode: no change, err=1.
//  POP with count==1: out_data=heap[0], count=0, skip SIFT_DN.
//  Status: full=(count==DEPTH), empty=(count==0), evaluated after op; out_data held 0 when out_v=0.
//  Equal keys never swap; key order among duplicates is not guaranteed.
//  count width $clog2(DEPTH+1); index math unsigned, no wrap (idx<count always).
// STRUCTURE
//  Package/header c3_heap_pkg: opcode constants, status bit indices, FSM state encoding.
//  One sub-module c3_heap_child_sel: combinational min-of-two-children select + swap flag.
//  Heap storage: DEPTH x DW register array, one read-modify-write swap per cycle.
// TESTING
//  Push 10,20,15,30,40 then POP x5 -> out_data 10,15,20,30,40; final status empty=1, count 0.
//  Push DEPTH keys, 17th PUSH 99 -> err=1, full=1, count 16; PEEK returns min unchanged.
//  POP on empty after reset -> out_v after 2 cycles, out_data=0, status 3'b011.
//  Push 5,5,3; POP x3 -> 3,5,5; rd/vrd2/in_vdata2 tags echoed per response.
//  in_v held high during busy -> exactly one response per accepted request, others dropped.
//  reset=0 during SIFT_DN -> no out_v, busy=0, count=0 next cycle; then PUSH 7, POP -> 7.

Source files
------------

// File: rtl/c3_heap_pkg.sv
// Shared constants for the C3 heap priority-queue responder.
// Opcodes carried on vrd1, status bit positions on out_vrd2, and the
// sequencer state encoding used by c3_heap_pq_unit.
package c3_heap_pkg;

  // Request opcodes (vrd1); 5..7 are reserved and answered with err=1.
  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_POP   = 3'd2;
  localparam logic [2:0] OP_PEEK  = 3'd3;
  localparam logic [2:0] OP_CLEAR = 3'd4;

  // Bit positions inside the {full,empty,err} status word.
  localparam int ST_ERR   = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_FULL  = 2;

  // Sequencer states. EXEC performs the opcode's single-cycle part,
  // the SIFT states walk the heap one level per cycle, RESP is the
  // one-cycle response strobe.
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_EXEC    = 3'd1;
  localparam logic [2:0] S_SIFT_UP = 3'd2;
  localparam logic [2:0] S_SIFT_DN = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

endpackage

// File: rtl/c3_heap_child_sel.sv
// Purpose: pick the smaller in-range child of a heap node and flag a swap.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle by the sift-down step.
// Ports: node/left/right keys, left_ok/right_ok (child index < count),
//        pick_right (right child is the smaller one), do_swap (child < node).
module c3_heap_child_sel #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] node_key,
  input  logic [DW-1:0] left_key,
  input  logic [DW-1:0] right_key,
  input  logic          left_ok,
  input  logic          right_ok,
  output logic          pick_right,
  output logic          do_swap
);

  logic [DW-1:0] min_key;

  // Ties go to the left child; the right child only counts when in range.
  assign pick_right = right_ok && (right_key < left_key);
  assign min_key    = pick_right ? right_key : left_key;
  // Strict compare: equal keys never move.
  assign do_swap    = left_ok && (min_key < node_key);

endmodule

// File: rtl/c3_heap_pq_unit.sv
// Purpose: min-heap priority queue answering C3 custom-instruction requests.
// Latency: accept->out_v 2 cycles (NOP/PEEK/CLEAR/errors), up to 2+log2(DEPTH) for PUSH/POP.
// Backpressure: busy=1 while a request is in flight; in_v seen then is dropped.
// Ports: clk/reset (sync, active-low); request in_v, rd, vrd1 (opcode), vrd2,
//        in_data (PUSH key), in_vdata1 (ignored), in_vdata2; response out_v strobe
//        with out_rd, out_vrd1 (tags), out_vrd2 {full,empty,err}, out_data,
//        out_vdata1 (count), out_vdata2 (echo). All out_* read 0 when out_v=0.
module c3_heap_pq_unit
  import c3_heap_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int VLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_v,
  input  logic [4:0]      rd,
  input  logic [2:0]      vrd1,
  input  logic [2:0]      vrd2,
  input  logic [DW-1:0]   in_data,
  input  logic [VLEN-1:0] in_vdata1,
  input  logic [VLEN-1:0] in_vdata2,
  output logic            busy,
  output logic            out_v,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_vrd1,
  output logic [2:0]      out_vrd2,
  output logic [DW-1:0]   out_data,
  output logic [VLEN-1:0] out_vdata1,
  output logic [VLEN-1:0] out_vdata2
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [2:0]      state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [4:0]      rd_q, rd_d;
  logic [2:0]      vtag_q, vtag_d;
  logic [2:0]      op_q, op_d;
  logic [DW-1:0]   key_q, key_d;
  logic [DW-1:0]   res_q, res_d;
  logic [VLEN-1:0] vdat_q, vdat_d;
  logic            err_q, err_d;
  logic [DW-1:0]   heap_q [DEPTH];
  logic [DW-1:0]   heap_d [DEPTH];

  logic [IW-1:0]   parent_idx;
  logic [IW+1:0]   left_w, right_w;
  logic            left_ok, right_ok, pick_right, do_swap;
  logic [IW-1:0]   child_idx;
  logic [CW-1:0]   count_m1;
  logic [2:0]      status;
  logic            unused_vdata1;

  assign unused_vdata1 = ^in_vdata1;

  assign busy  = (state_q != S_IDLE) && (state_q != S_RESP);
  assign out_v = (state_q == S_RESP);

  // Index arithmetic: child indices need two extra bits so 2i+2 cannot wrap.
  assign parent_idx = (idx_q - IW'(1)) >> 1;
  assign left_w     = {1'b0, idx_q, 1'b1};
  assign right_w    = left_w + (IW+2)'(1);
  assign left_ok    = left_w  < (IW+2)'(count_q);
  assign right_ok   = right_w < (IW+2)'(count_q);
  assign child_idx  = pick_right ? right_w[IW-1:0] : left_w[IW-1:0];
  assign count_m1   = count_q - CW'(1);

  c3_heap_child_sel #(.DW(DW)) u_child_sel (
    .node_key   (heap_q[idx_q]),
    .left_key   (heap_q[left_w[IW-1:0]]),
    .right_key  (heap_q[right_w[IW-1:0]]),
    .left_ok    (left_ok),
    .right_ok   (right_ok),
    .pick_right (pick_right),
    .do_swap    (do_swap)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    rd_d    = rd_q;
    vtag_d  = vtag_q;
    op_d    = op_q;
    key_d   = key_q;
    res_d   = res_q;
    vdat_d  = vdat_q;
    err_d   = err_q;
    for (int i = 0; i < DEPTH; i++) heap_d[i] = heap_q[i];

    case (state_q)
      // busy is low in both states, so any in_v here is accepted.
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        if (in_v) begin
          rd_d    = rd;
          vtag_d  = vrd2;
          op_d    = vrd1;
          key_d   = in_data;
          vdat_d  = in_vdata2;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        err_d   = 1'b0;
        res_d   = '0;
        state_d = S_RESP;
        case (op_q)
          OP_NOP: ;
          OP_PUSH: begin
            if (count_q == CW'(DEPTH)) begin
              err_d = 1'b1;
            end else begin
              heap_d[count_q[IW-1:0]] = key_q;
              idx_d   = count_q[IW-1:0];
              count_d = count_q + CW'(1);
              if (count_q != '0) state_d = S_SIFT_UP;
            end
          end
          OP_POP: begin
            if (count_q == '0) begin
              err_d = 1'b1;
            end else begin
              res_d   = heap_q[0];
              count_d = count_m1;
              // Last leaf moves to the root; only sift when two or more remain.
              if (count_q > CW'(1)) begin
                heap_d[0] = heap_q[count_m1[IW-1:0]];
                idx_d     = '0;
                if (count_q > CW'(2)) state_d = S_SIFT_DN;
              end
            end
          end
          OP_PEEK: begin
            if (count_q == '0) err_d = 1'b1;
            else               res_d = heap_q[0];
          end
          OP_CLEAR: count_d = '0;
          default:  err_d = 1'b1;
        endcase
      end
      S_SIFT_UP: begin
        if (heap_q[idx_q] < heap_q[parent_idx]) begin
          heap_d[idx_q]      = heap_q[parent_idx];
          heap_d[parent_idx] = heap_q[idx_q];
          idx_d              = parent_idx;
          // Reaching the root ends the walk without a further compare cycle.
          if (parent_idx == '0) state_d = S_RESP;
        end else begin
          state_d = S_RESP;
        end
      end
      S_SIFT_DN: begin
        if (do_swap) begin
          heap_d[idx_q]     = heap_q[child_idx];
          heap_d[child_idx] = heap_q[idx_q];
          idx_d             = child_idx;
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      rd_q    <= '0;
      vtag_q  <= '0;
      op_q    <= '0;
      key_q   <= '0;
      res_q   <= '0;
      vdat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      rd_q    <= rd_d;
      vtag_q  <= vtag_d;
      op_q    <= op_d;
      key_q   <= key_d;
      res_q   <= res_d;
      vdat_q  <= vdat_d;
      err_q   <= err_d;
    end
  end

  // Heap storage is not reset; writes are frozen while reset is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) heap_q[i] <= heap_d[i];
    end
  end

  always_comb begin
    status           = '0;
    status[ST_FULL]  = (count_q == CW'(DEPTH));
    status[ST_EMPTY] = (count_q == '0);
    status[ST_ERR]   = err_q;
  end

  assign out_rd     = out_v ? rd_q            : '0;
  assign out_vrd1   = out_v ? vtag_q          : '0;
  assign out_vrd2   = out_v ? status          : '0;
  assign out_data   = out_v ? res_q           : '0;
  assign out_vdata1 = out_v ? VLEN'(count_q)  : '0;
  assign out_vdata2 = out_v ? vdat_q          : '0;

endmodule

// File: tb/tb_c3_heap_pq_unit.sv
// Bench for c3_heap_pq_unit: sorted-queue reference model, randomized ops,
// directed scenarios for ordering, full/empty, duplicates, dropped requests
// and reset during an operation.
module tb_c3_heap_pq_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_v;
  logic [4:0]  rd;
  logic [2:0]  vrd1, vrd2;
  logic [31:0] in_data, in_vdata1, in_vdata2;
  logic        busy, out_v;
  logic [4:0]  out_rd;
  logic [2:0]  out_vrd1, out_vrd2;
  logic [31:0] out_data, out_vdata1, out_vdata2;

  int checks = 0;
  int errors = 0;
  int unsigned mq[$];  // reference contents, kept ascending

  c3_heap_pq_unit #(.DW(32), .DEPTH(16), .VLEN(32)) dut (
    .clk(clk), .reset(reset), .in_v(in_v), .rd(rd), .vrd1(vrd1), .vrd2(vrd2),
    .in_data(in_data), .in_vdata1(in_vdata1), .in_vdata2(in_vdata2),
    .busy(busy), .out_v(out_v), .out_rd(out_rd), .out_vrd1(out_vrd1),
    .out_vrd2(out_vrd2), .out_data(out_data), .out_vdata1(out_vdata1),
    .out_vdata2(out_vdata2)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end

  // Reference: apply an opcode to the sorted queue, return expected results.
  task automatic m_apply(input logic [2:0] op, input logic [31:0] d,
                         output logic [31:0] e_data, output logic [2:0] e_st,
                         output logic [31:0] e_cnt, output bit fixed);
    bit err = 0;
    int i = 0;
    e_data = 0;
    fixed  = 1;
    case (op)
      3'd0: ;
      3'd1: if (mq.size() == 16) err = 1;
            else begin
              while (i < mq.size() && mq[i] <= d) i++;
              mq.insert(i, d);
              fixed = 0;
            end
      3'd2: if (mq.size() == 0) err = 1;
            else begin e_data = mq.pop_front(); fixed = 0; end
      3'd3: if (mq.size() == 0) err = 1; else e_data = mq[0];
      3'd4: mq.delete();
      default: err = 1;
    endcase
    e_st  = {mq.size() == 16, mq.size() == 0, err};
    e_cnt = mq.size();
  endtask

  // Drive one request once busy is low and capture its response.
  // lat counts negedges from accept to out_v; 12 means no response seen.
  task automatic issue(input logic [2:0] op, input logic [4:0] t_rd, input logic [2:0] t_vt,
                       input logic [31:0] d, input logic [31:0] vd, output int lat,
                       output logic [31:0] r_data, output logic [2:0] r_st,
                       output logic [31:0] r_cnt, output logic [4:0] r_rd,
                       output logic [2:0] r_vt, output logic [31:0] r_vd);
    int w = 0;
    while (busy && w < 50) begin @(negedge clk); w++; end
    in_v = 1; rd = t_rd; vrd1 = op; vrd2 = t_vt; in_data = d;
    in_vdata1 = $urandom; in_vdata2 = vd;
    @(negedge clk);
    in_v = 0; in_data = $urandom; in_vdata2 = $urandom; rd = 5'($urandom); vrd2 = 3'($urandom);
    lat = 1;
    while (!out_v && lat < 12) begin @(negedge clk); lat++; end
    r_data = out_data; r_st = out_vrd2; r_cnt = out_vdata1;
    r_rd = out_rd; r_vt = out_vrd1; r_vd = out_vdata2;
  endtask

  task automatic test_reset;
    reset = 0; in_v = 0; rd = 0; vrd1 = 0; vrd2 = 0; in_data = 0; in_vdata1 = 0; in_vdata2 = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, out_v, out_rd, out_vrd1, out_vrd2, out_data, out_vdata1, out_vdata2} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b out_v=%b data=%h st=%b cnt=%0d", busy, out_v, out_data, out_vrd2, out_vdata1);
    end
    reset = 1;
    @(negedge clk);
    mq.delete();
  endtask

  task automatic test_empty_pop;
    int lat; logic [31:0] d, c, vd; logic [2:0] s, vt; logic [4:0] r;
    issue(3'd2, 5'd9, 3'd4, 32'h0, 32'hCAFE0001, lat, d, s, c, r, vt, vd);
    checks++;
    if (lat !== 2 || d !== 0 || s !== 3'b011 || c !== 0) begin
      errors++;
      $display("FAIL empty_pop: lat=%0d data=%h st=%b cnt=%0d want lat=2 data=0 st=011 cnt=0", lat, d, s, c);
    end
    @(negedge clk);
    checks++;
    if (out_v !== 0 || out_data !== 0) begin
      errors++;
      $display("FAIL strobe_one_cycle: out_v=%b out_data=%h want 0/0", out_v, out_data);
    end
  endtask

  task automatic test_ordered_pops;
    int lat; logic [31:0] d, c, vd, ed, ec; logic [2:0] s, vt, es; logic [4:0] r; bit f;
    int unsigned keys[5] = '{10, 20, 15, 30, 40};
    int unsigned want[5] = '{10, 15, 20, 30, 40};
    foreach (keys[i]) begin
      issue(3'd1, 5'(i), 3'd1, keys[i], 32'h0, lat, d, s, c, r, vt, vd);
      m_apply(3'd1, keys[i], ed, es, ec, f);
    end
    foreach (want[i]) begin
      issue(3'd2, 5'(i), 3'd2, 32'h0, 32'h0, lat, d, s, c, r, vt, vd);
      m_apply(3'd2, 0, ed, es, ec, f);
      checks++;
      if (d !== want[i] || lat > 6) begin
        errors++;
        $display("FAIL ordered_pop[%0d]: data=%0d lat=%0d want %0d lat<=6", i, d, lat, want[i]);
      end
    end
    checks++;
    if (s !== 3'b010 || c !== 0) begin
      errors++;
      $display("FAIL ordered_final: st=%b cnt=%0d want 010/0", s, c);
    end
  endtask

  task automatic test_full;
    int lat; logic [31:0] d, c, vd, ed, ec, k; logic [2:0] s, vt, es; logic [4:0] r; bit f;
    issue(3'd4, 0, 0, 0, 0, lat, d, s, c, r, vt, vd);
    m_apply(3'd4, 0, ed, es, ec, f);
    for (int i = 0; i < 16; i++) begin
      k = $urandom_range(100, 100000);
      issue(3'd1, 5'(i), 3'd3, k, 32'h0, lat, d, s, c, r, vt, vd);
      m_apply(3'd1, k, ed, es, ec, f);
      checks++;
      if (c !== i + 1 || lat < 2 || lat > 6) begin
        errors++;
        $display("FAIL fill[%0d]: cnt=%0d lat=%0d want cnt=%0d lat 2..6", i, c, lat, i + 1);
      end
    end
    issue(3'd1, 5'd17, 3'd5, 32'd99, 32'h0, lat, d, s, c, r, vt, vd);
    m_apply(3'd1, 99, ed, es, ec, f);
    checks++;
    if (s !== 3'b101 || c !== 16 || lat !== 2) begin
      errors++;
      $display("FAIL push_full: st=%b cnt=%0d lat=%0d want 101/16/2", s, c, lat);
    end
    issue(3'd3, 5'd18, 3'd6, 0, 0, lat, d, s, c, r, vt, vd);
    m_apply(3'd3, 0, ed, es, ec, f);
    checks++;
    if (d !== ed || s !== 3'b100 || c !== 16) begin
      errors++;
      $display("FAIL peek_full: data=%0d st=%b cnt=%0d want %0d/100/16", d, s, c, ed);
    end
  endtask

  task automatic test_dups_tags;
    int lat; logic [31:0] d, c, vd, ed, ec, tvd; logic [2:0] s, vt, es, tvt; logic [4:0] r, trd; bit f;
    int unsigned keys[3] = '{5, 5, 3};
    int unsigned want[3] = '{3, 5, 5};
    issue(3'd4, 0, 0, 0, 0, lat, d, s, c, r, vt, vd);
    m_apply(3'd4, 0, ed, es, ec, f);
    foreach (keys[i]) begin
      issue(3'd1, 5'(i), 3'd0, keys[i], 0, lat, d, s, c, r, vt, vd);
      m_apply(3'd1, keys[i], ed, es, ec, f);
    end
    foreach (want[i]) begin
      trd = 5'($urandom); tvt = 3'($urandom); tvd = $urandom;
      issue(3'd2, trd, tvt, 0, tvd, lat, d, s, c, r, vt, vd);
      m_apply(3'd2, 0, ed, es, ec, f);
      checks++;
      if (d !== want[i] || c !== ec) begin
        errors++;
        $display("FAIL dup_pop[%0d]: data=%0d cnt=%0d want %0d/%0d", i, d, c, want[i], ec);
      end
      checks++;
      if (r !== trd || vt !== tvt || vd !== tvd) begin
        errors++;
        $display("FAIL tag_echo[%0d]: rd=%0d vt=%0d vd=%h want %0d/%0d/%h", i, r, vt, vd, trd, tvt, tvd);
      end
    end
  endtask

  task automatic test_hold_in_v;
    int lat, resp = 0; bit prev = 0, dbl = 0;
    logic [31:0] d, c, vd, ed, ec; logic [2:0] s, vt, es; logic [4:0] r; bit f;
    issue(3'd4, 0, 0, 0, 0, lat, d, s, c, r, vt, vd);
    m_apply(3'd4, 0, ed, es, ec, f);
    in_v = 1; vrd1 = 3'd1; in_data = 7; rd = 3; vrd2 = 1;
    for (int i = 0; i < 30; i++) begin
      if (i == 20) in_v = 0;
      @(negedge clk);
      if (out_v) begin resp++; if (prev) dbl = 1; end
      prev = out_v;
    end
    for (int i = 0; i < resp; i++) m_apply(3'd1, 7, ed, es, ec, f);
    checks++;
    if (resp < 3 || resp > 10 || dbl) begin
      errors++;
      $display("FAIL hold_resp_count: responses=%0d back_to_back_strobe=%0d want 3..10 and 0", resp, dbl);
    end
    issue(3'd0, 0, 0, 0, 0, lat, d, s, c, r, vt, vd);
    m_apply(3'd0, 0, ed, es, ec, f);
    checks++;
    if (c !== resp) begin
      errors++;
      $display("FAIL hold_count: cnt=%0d want %0d (one entry per response)", c, resp);
    end
  endtask

  task automatic test_reset_mid;
    int lat; bit seen = 0;
    logic [31:0] d, c, vd, ed, ec; logic [2:0] s, vt, es; logic [4:0] r; bit f;
    int unsigned keys[4] = '{10, 20, 30, 40};
    issue(3'd4, 0, 0, 0, 0, lat, d, s, c, r, vt, vd);
    m_apply(3'd4, 0, ed, es, ec, f);
    foreach (keys[i]) issue(3'd1, 0, 0, keys[i], 0, lat, d, s, c, r, vt, vd);
    in_v = 1; vrd1 = 3'd2;
    @(negedge clk); in_v = 0;
    if (out_v) seen = 1;
    @(negedge clk);
    if (out_v) seen = 1;
    reset = 0;
    @(negedge clk);
    reset = 1;
    checks++;
    if (out_v !== 0 || busy !== 0 || seen) begin
      errors++;
      $display("FAIL reset_mid: out_v=%b busy=%b early_resp=%0d want 0/0/0", out_v, busy, seen);
    end
    mq.delete();
    issue(3'd0, 0, 0, 0, 0, lat, d, s, c, r, vt, vd);
    checks++;
    if (c !== 0 || s !== 3'b010) begin
      errors++;
      $display("FAIL reset_mid_count: cnt=%0d st=%b want 0/010", c, s);
    end
    issue(3'd1, 0, 0, 7, 0, lat, d, s, c, r, vt, vd);
    issue(3'd2, 0, 0, 0, 0, lat, d, s, c, r, vt, vd);
    checks++;
    if (d !== 7 || c !== 0) begin
      errors++;
      $display("FAIL reset_mid_pop: data=%0d cnt=%0d want 7/0", d, c);
    end
  endtask

  task automatic test_random;
    int lat, sel;
    logic [31:0] d, c, vd, ed, ec, k, tvd; logic [2:0] s, vt, es, op, tvt; logic [4:0] r, trd; bit f;
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 99);
      if      (sel < 45) op = 3'd1;
      else if (sel < 75) op = 3'd2;
      else if (sel < 85) op = 3'd3;
      else if (sel < 90) op = 3'd0;
      else if (sel < 93) op = 3'd4;
      else               op = 3'($urandom_range(5, 7));
      k = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 40));
      trd = 5'($urandom); tvt = 3'($urandom); tvd = $urandom;
      issue(op, trd, tvt, k, tvd, lat, d, s, c, r, vt, vd);
      m_apply(op, k, ed, es, ec, f);
      checks++;
      if ({d, s, c, r, vt, vd} !== {ed, es, ec, trd, tvt, tvd}) begin
        errors++;
        $display("FAIL rand[%0d] op=%0d: data=%h st=%b cnt=%0d rd=%0d vt=%0d vd=%h want data=%h st=%b cnt=%0d rd=%0d vt=%0d vd=%h",
                 n, op, d, s, c, r, vt, vd, ed, es, ec, trd, tvt, tvd);
      end
      checks++;
      if ((f && lat !== 2) || (!f && (lat < 2 || lat > 6))) begin
        errors++;
        $display("FAIL rand_lat[%0d] op=%0d: lat=%0d want %s", n, op, lat, f ? "2" : "2..6");
      end
    end
  endtask

  initial begin
    test_reset();
    test_empty_pop();
    test_ordered_pops();
    test_full();
    test_dups_tags();
    test_hold_in_v();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
